// File: rtl/pipeline_interlock_if.sv
// Decode-stage hazard interface: instruction fields in, issue/stall decision and scoreboard status out.
interface pipeline_interlock_if #(
    parameter int unsigned RAW   = 3,
    parameter int unsigned CNT_W = 16
);
    logic                  id_valid;
    logic [RAW-1:0]        AA;
    logic [RAW-1:0]        BA;
    logic [RAW-1:0]        DA;
    logic                  MA;
    logic                  MB;
    logic                  RW;
    logic                  flush;
    logic                  issue;
    logic                  stall;
    logic                  bubble;
    logic [(2**RAW)-1:0]   busy_mask;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, AA, BA, DA, MA, MB, RW, flush,
        input  issue, stall, bubble, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, AA, BA, DA, MA, MB, RW, flush,
        output issue, stall, bubble, busy_mask, stall_cnt
    );
endinterface

// File: rtl/pipeline_interlock.sv
// RAW-hazard interlock: scoreboard of in-flight destinations (EX..WB), issue/stall decision,
// bubble injection and a saturating stall-cycle counter.
module pipeline_interlock #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned RAW       = 3,
    parameter int unsigned CNT_W     = 16,
    parameter bit          BYPASS_WB = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    pipeline_interlock_if.slave bus
);
    localparam int unsigned NREG = 2 ** RAW;
    // With a write-through register file the WB slot needs no interlock.
    localparam logic [DEPTH-1:0] CHK_MASK = BYPASS_WB ?
        DEPTH'((33'd1 << (DEPTH - 1)) - 33'd1) : {DEPTH{1'b1}};

    logic [DEPTH-1:0]          slot_v_q, slot_v_d;
    logic [DEPTH-1:0][RAW-1:0] slot_dest_q, slot_dest_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

    logic             haz_a_c, haz_b_c;
    logic             stall_c, issue_c;
    logic [DEPTH-1:0] chk_v_c;
    logic [NREG-1:0]  busy_c;

    // Source compare against older in-flight instructions only.
    always_comb begin
        haz_a_c = 1'b0;
        haz_b_c = 1'b0;
        chk_v_c = slot_v_q & CHK_MASK;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (chk_v_c[k] && (slot_dest_q[k] == bus.AA)) haz_a_c = 1'b1;
            if (chk_v_c[k] && (slot_dest_q[k] == bus.BA)) haz_b_c = 1'b1;
        end
        haz_a_c = haz_a_c & ~bus.MA & (bus.AA != '0);
        haz_b_c = haz_b_c & ~bus.MB & (bus.BA != '0);
        stall_c = bus.id_valid & ~bus.flush & (haz_a_c | haz_b_c);
        issue_c = bus.id_valid & ~bus.flush & ~stall_c;
    end

    // Scoreboard shift and stall counter next state.
    always_comb begin
        slot_v_d    = '0;
        slot_dest_d = '0;
        stall_cnt_d = stall_cnt_q;
        if (!bus.flush) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                slot_v_d[i]    = slot_v_q[i-1];
                slot_dest_d[i] = slot_dest_q[i-1];
            end
            slot_v_d[0]    = issue_c & bus.RW & (bus.DA != '0);
            slot_dest_d[0] = bus.DA;
        end
        if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pending-register mask over every valid slot, including WB.
    always_comb begin
        busy_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (slot_v_q[i]) busy_c[slot_dest_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_v_q    <= '0;
            slot_dest_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_dest_q <= slot_dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.issue     = issue_c;
    assign bus.stall     = stall_c;
    assign bus.bubble    = ~issue_c;
    assign bus.busy_mask = busy_c;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
